if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage pipeline, directly upstream of instr_mem.
//  - Owns the PC register and drives iaddr/cs_n into instr_mem.
//  - Captures the returned instrCode, with its PC, into the IF/ID pipeline register for decode.
//  - Handles decode/hazard stalls and branch/jump redirects (flush) coming back from EX.

---
 rtl/if_stage.sv | 58 +++++
 tb/tb_if_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: PC register, instr_mem fetch and IF/ID register; MISALIGN_CHECK_EN traps misaligned redirects
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] iaddr,
  output logic        cs_n,
  input  logic [31:0] instrCode,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign,
  output logic [31:0] misalign_addr
);
  logic [31:0] pc;
  logic [31:0] redirect_tgt;
  assign iaddr = {pc[31:2], 2'b00};
  assign cs_n  = rst;
`ifdef MISALIGN_CHECK_EN
  logic bad;
  assign bad          = redirect && |redirect_pc[1:0];
  assign redirect_tgt = bad ? pc : redirect_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign      <= 1'b0;
      misalign_addr <= 32'h0;
    end else begin
      misalign <= bad;
      if (bad) misalign_addr <= redirect_pc;
    end
  end
`else
  assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
  assign misalign      = 1'b0;
  assign misalign_addr = 32'h0;
`endif
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      pc          <= rst ? RESET_PC : redirect_tgt;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h4;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= iaddr + 32'h4;
      if_id_pc    <= iaddr;
      if_id_pc4   <= iaddr + 32'h4;
      if_id_instr <= instrCode;
      if_id_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus against a fetch model kept in terms of next-fetch address and IF/ID pc
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, iaddr, instrCode, if_id_pc, if_id_pc4, if_id_instr, misalign_addr;
  logic        cs_n, if_id_valid, misalign;
  int          pass = 0, total = 0;
  logic [31:0] m_pc, m_ipc, m_maddr;
  logic        m_valid, m_mis;
  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .iaddr(iaddr), .cs_n(cs_n), .instrCode(instrCode), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );
  always #5 clk = ~clk;
  assign instrCode = iaddr >> 2;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0; m_ipc <= 32'h0; m_valid <= 1'b0; m_mis <= 1'b0; m_maddr <= 32'h0;
    end else begin
      m_mis <= 1'b0;
      if (redirect) begin
        m_valid <= 1'b0;
`ifdef MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) begin
          m_mis <= 1'b1;
          m_maddr <= redirect_pc;
        end else m_pc <= redirect_pc;
`else
        m_pc <= redirect_pc & ~32'd3;
`endif
      end else if (!stall) begin
        m_valid <= 1'b1;
        m_ipc <= m_pc;
        m_pc <= m_pc + 32'd4;
      end
    end
  end
  always @(negedge clk) begin
    chk("iaddr", iaddr, m_pc);
    chk("cs_n", {31'h0, cs_n}, {31'h0, rst});
    chk("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    chk("if_id_pc", if_id_pc, m_valid ? m_ipc : 32'h0);
    chk("if_id_pc4", if_id_pc4, m_valid ? m_ipc + 32'd4 : 32'h4);
    chk("if_id_instr", if_id_instr, m_valid ? m_ipc >> 2 : 32'h13);
    chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
    chk("misalign_addr", misalign_addr, m_maddr);
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #2;
    end
  endtask
  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
  endtask
  initial begin
    drive(1, 0, 0, 0);
    tick(2);
    chk("lit_rst_iaddr", iaddr, 32'h0);
    chk("lit_rst_csn", {31'h0, cs_n}, 32'h1);
    chk("lit_rst_instr", if_id_instr, 32'h13);
    chk("lit_rst_pc4", if_id_pc4, 32'h4);
    drive(0, 0, 0, 0);
    tick();
    chk("lit_first_valid", {31'h0, if_id_valid}, 32'h1);
    chk("lit_first_pc", if_id_pc, 32'h0);
    chk("lit_first_instr", if_id_instr, 32'h0);
    chk("lit_first_iaddr", iaddr, 32'h4);
    tick();
    drive(0, 1, 0, 0);
    tick(3);
    chk("lit_stall_iaddr", iaddr, 32'h8);
    chk("lit_stall_pc", if_id_pc, 32'h4);
    chk("lit_stall_instr", if_id_instr, 32'h1);
    drive(0, 0, 0, 0);
    tick();
    chk("lit_resume_pc", if_id_pc, 32'h8);
    tick();
    chk("lit_pre_redir_iaddr", iaddr, 32'h10);
    drive(0, 0, 1, 32'h40);
    tick();
    chk("lit_redir_iaddr", iaddr, 32'h40);
    chk("lit_redir_valid", {31'h0, if_id_valid}, 32'h0);
    chk("lit_redir_instr", if_id_instr, 32'h13);
    drive(0, 0, 0, 0);
    tick();
    chk("lit_post_redir_pc", if_id_pc, 32'h40);
    chk("lit_post_redir_instr", if_id_instr, 32'h10);
    drive(0, 1, 1, 32'h80);
    tick();
    chk("lit_redir_stall_iaddr", iaddr, 32'h80);
    chk("lit_redir_stall_valid", {31'h0, if_id_valid}, 32'h0);
    drive(0, 0, 1, 32'h100);
    tick();
    redirect_pc = 32'h200;
    tick();
    chk("lit_b2b_iaddr", iaddr, 32'h200);
    chk("lit_b2b_valid", {31'h0, if_id_valid}, 32'h0);
    drive(0, 0, 1, 32'hFFFF_FFF8);
    tick();
    drive(0, 0, 0, 0);
    tick(2);
    chk("lit_wrap_iaddr", iaddr, 32'h0);
    chk("lit_wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("lit_wrap_pc4", if_id_pc4, 32'h0);
    chk("lit_wrap_instr", if_id_instr, 32'h3FFF_FFFF);
    drive(0, 0, 1, 32'h20);
    tick();
    drive(0, 0, 1, 32'h42);
    tick();
`ifdef MISALIGN_CHECK_EN
    chk("lit_mis_pulse", {31'h0, misalign}, 32'h1);
    chk("lit_mis_addr", misalign_addr, 32'h42);
    chk("lit_mis_iaddr", iaddr, 32'h20);
`else
    chk("lit_mis_pulse", {31'h0, misalign}, 32'h0);
    chk("lit_mis_addr", misalign_addr, 32'h0);
    chk("lit_mis_iaddr", iaddr, 32'h40);
`endif
    chk("lit_mis_valid", {31'h0, if_id_valid}, 32'h0);
    drive(0, 0, 0, 0);
    tick();
    chk("lit_mis_end", {31'h0, misalign}, 32'h0);
    drive(1, 1, 1, 32'h300);
    tick();
    chk("lit_mid_rst_iaddr", iaddr, 32'h0);
    chk("lit_mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("lit_mid_rst_maddr", misalign_addr, 32'h0);
    drive(0, 0, 0, 0);
    tick();
    chk("lit_restart_pc", if_id_pc, 32'h0);
    chk("lit_restart_iaddr", iaddr, 32'h4);
    tick(2);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
